// File: rtl/fpadd_12bit_accumulator.sv
// Packet-wise floating-point sum over a valid/ready stream of 14-bit FloPoCo
// operands (wE=5, wF=6), closing the FPADD_12bit loop through a registered accumulator.

module FPADD_12bit (
    input  logic [13:0] X,
    input  logic [13:0] Y,
    output logic [13:0] R
);
    localparam logic [13:0] NAN_C = 14'h3000;

    logic              swap, sub, sticky, rnd_up;
    logic [13:0]       a, b;
    logic [4:0]        d, p;
    logic [31:0]       b_wide;
    logic [15:0]       ma, mb;
    logic [16:0]       s, norm;
    logic [7:0]        sig_r, e_u;
    logic signed [7:0] e;
    logic [5:0]        unused_bits;

    // a is the operand with the larger magnitude, so ma >= mb and the result takes a's sign
    assign swap = (Y[10:0] > X[10:0]);
    assign a    = swap ? Y : X;
    assign b    = swap ? X : Y;
    assign d    = a[10:6] - b[10:6];
    assign sub  = a[11] ^ b[11];

    // Nine guard bits below the significand; bits shifted further out are jammed into the LSB
    assign ma     = {1'b1, a[5:0], 9'b0};
    assign b_wide = {1'b1, b[5:0], 9'b0, 16'b0} >> d;
    assign mb     = b_wide[31:16] | {15'b0, |b_wide[15:0]};
    assign s      = sub ? ({1'b0, ma} - {1'b0, mb}) : ({1'b0, ma} + {1'b0, mb});

    always_comb begin
        p = 5'd0;
        for (int i = 0; i < 17; i++) begin
            if (s[i]) p = 5'(i);
        end
    end

    assign norm   = s << (5'd16 - p);
    assign sticky = |norm[8:0];
    assign rnd_up = norm[9] & (sticky | norm[10]);
    assign sig_r  = {1'b0, norm[16:10]} + {7'b0, rnd_up};
    assign e_u    = {3'b0, a[10:6]} + {3'b0, p} + {7'b0, sig_r[7]} - 8'd15;
    assign e      = e_u;

    assign unused_bits = {a[13:12], b[13:12], sig_r[6], b_wide[0]};

    always_comb begin
        R = 14'h0000;
        if (X[13:12] == 2'b11 || Y[13:12] == 2'b11)
            R = NAN_C;
        else if (X[13:12] == 2'b10 && Y[13:12] == 2'b10)
            R = (X[11] == Y[11]) ? {2'b10, X[11], 11'b0} : NAN_C;
        else if (X[13:12] == 2'b10)
            R = {2'b10, X[11], 11'b0};
        else if (Y[13:12] == 2'b10)
            R = {2'b10, Y[11], 11'b0};
        else if (X[13:12] == 2'b00 && Y[13:12] == 2'b00)
            R = {2'b00, X[11] & Y[11], 11'b0};
        else if (X[13:12] == 2'b00)
            R = Y;
        else if (Y[13:12] == 2'b00)
            R = X;
        else if (s == 17'd0)
            R = 14'h0000;
        else if (e > 8'sd31)
            R = {2'b10, a[11], 11'b0};
        else if (e < 8'sd0)
            R = {2'b00, a[11], 11'b0};
        else
            R = {2'b01, a[11], e[4:0], sig_r[5:0]};
    end
endmodule

module fpadd_12bit_accumulator #(
    parameter int  MAX_TERMS = 64,
    localparam int CW        = $clog2(MAX_TERMS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [13:0]   in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [13:0]   out_data,
    output logic [CW-1:0] out_count,
    output logic          out_trunc
);
    typedef enum logic {S_ACC = 1'b0, S_HOLD = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [13:0]   acc_q, acc_d, sum_c, out_data_q, out_data_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc, out_count_q, out_count_d;
    logic          out_trunc_q, out_trunc_d;
    logic          accept, done;

    FPADD_12bit u_add (.X(acc_q), .Y(in_data), .R(sum_c));

    assign cnt_inc = cnt_q + CW'(1);
    assign accept  = in_valid & (state_q == S_ACC);
    assign done    = in_last | (cnt_inc == CW'(MAX_TERMS));

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_trunc_d = out_trunc_q;
        case (state_q)
            S_ACC: begin
                if (accept) begin
                    acc_d = sum_c;
                    cnt_d = cnt_inc;
                    if (done) begin
                        out_data_d  = sum_c;
                        out_count_d = cnt_inc;
                        out_trunc_d = ~in_last;
                        acc_d       = 14'h0000;
                        cnt_d       = '0;
                        state_d     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) state_d = S_ACC;
            end
            default: state_d = S_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_ACC;
            acc_q       <= 14'h0000;
            cnt_q       <= '0;
            out_data_q  <= 14'h0000;
            out_count_q <= '0;
            out_trunc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_trunc_q <= out_trunc_d;
        end
    end

    // Single-bit state: both handshake outputs are straight register decodes
    assign in_ready  = (state_q == S_ACC);
    assign out_valid = (state_q == S_HOLD);
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_trunc = out_trunc_q;
endmodule

// File: tb/tb_fpadd_12bit_accumulator.sv
// Directed bench for fpadd_12bit_accumulator with MAX_TERMS=4; inputs and checks on the falling edge.

module tb_fpadd_12bit_accumulator;
    localparam int MT = 4;
    localparam int CW = $clog2(MT + 1);

    logic          clk = 1'b0;
    logic          rst, in_valid, in_last, out_ready;
    logic [13:0]   in_data;
    logic          in_ready, out_valid, out_trunc;
    logic [13:0]   out_data;
    logic [CW-1:0] out_count;
    int            nvec = 0;
    int            nerr = 0;

    always #5 clk = ~clk;

    fpadd_12bit_accumulator #(.MAX_TERMS(MT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_trunc(out_trunc)
    );

    task automatic put(input logic [13:0] d, input logic last);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = last;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0; in_data = 14'h0000; in_last = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_data = 14'h13C0; in_last = 1'b1;
        @(negedge clk); @(negedge clk);
        nvec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 14'h0000 ||
            out_count !== 3'd0 || out_trunc !== 1'b0) begin
            nerr++;
            $display("FAIL reset: rdy=%b vld=%b data=%h cnt=%0d tr=%b want 1 0 0000 0 0",
                     in_ready, out_valid, out_data, out_count, out_trunc);
        end
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic test_basic();
        put(14'h13C0, 1'b0); put(14'h1400, 1'b0); put(14'h13C0, 1'b1);
        idle();
        nvec++;
        if (out_valid !== 1'b1 || out_data !== 14'h1440 || out_count !== 3'd3 ||
            out_trunc !== 1'b0 || in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL basic_sum: vld=%b data=%h cnt=%0d tr=%b rdy=%b want 1 1440 3 0 0",
                     out_valid, out_data, out_count, out_trunc, in_ready);
        end
        @(negedge clk);
        nvec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL basic_release: rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_single();
        put(14'h1420, 1'b1);
        idle();
        nvec++;
        if (out_valid !== 1'b1 || out_data !== 14'h1420 || out_count !== 3'd1 || out_trunc !== 1'b0) begin
            nerr++;
            $display("FAIL single: vld=%b data=%h cnt=%0d tr=%b want 1 1420 1 0",
                     out_valid, out_data, out_count, out_trunc);
        end
        idle();
    endtask

    task automatic test_cancel();
        put(14'h13C0, 1'b0); put(14'h1BC0, 1'b1);
        idle();
        nvec++;
        if (out_valid !== 1'b1 || out_data[13:12] !== 2'b00 || out_count !== 3'd2) begin
            nerr++;
            $display("FAIL cancel: vld=%b data=%h cnt=%0d want 1 exn00 2",
                     out_valid, out_data, out_count);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        put(14'h13C0, 1'b0); put(14'h13C0, 1'b1);
        put(14'h1420, 1'b1);
        nvec++;
        if (out_valid !== 1'b1 || out_data !== 14'h1400 || out_count !== 3'd2 || in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_first: vld=%b data=%h cnt=%0d rdy=%b want 1 1400 2 0",
                     out_valid, out_data, out_count, in_ready);
        end
        @(negedge clk);
        nvec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL b2b_bubble: vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        idle();
        nvec++;
        if (out_valid !== 1'b1 || out_data !== 14'h1420 || out_count !== 3'd1) begin
            nerr++;
            $display("FAIL b2b_second: vld=%b data=%h cnt=%0d want 1 1420 1",
                     out_valid, out_data, out_count);
        end
        idle();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        put(14'h1400, 1'b1);
        for (int i = 0; i < 5; i++) begin
            idle();
            nvec++;
            if (out_valid !== 1'b1 || out_data !== 14'h1400 || out_count !== 3'd1 || in_ready !== 1'b0) begin
                nerr++;
                $display("FAIL stall_%0d: vld=%b data=%h cnt=%0d rdy=%b want 1 1400 1 0",
                         i, out_valid, out_data, out_count, in_ready);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        nvec++;
        if (out_valid !== 1'b1 || out_data !== 14'h1400 || in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL stall_accept: vld=%b data=%h rdy=%b want 1 1400 0",
                     out_valid, out_data, in_ready);
        end
        @(negedge clk);
        nvec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL stall_release: vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_trunc();
        for (int i = 0; i < 4; i++) put(14'h13C0, 1'b0);
        put(14'h13C0, 1'b1);
        nvec++;
        if (out_valid !== 1'b1 || out_data !== 14'h1440 || out_count !== 3'd4 ||
            out_trunc !== 1'b1 || in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL trunc_first: vld=%b data=%h cnt=%0d tr=%b rdy=%b want 1 1440 4 1 0",
                     out_valid, out_data, out_count, out_trunc, in_ready);
        end
        @(negedge clk);
        nvec++;
        if (in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL trunc_ready: rdy=%b want 1", in_ready);
        end
        idle();
        nvec++;
        if (out_valid !== 1'b1 || out_data !== 14'h13C0 || out_count !== 3'd1 || out_trunc !== 1'b0) begin
            nerr++;
            $display("FAIL trunc_rest: vld=%b data=%h cnt=%0d tr=%b want 1 13c0 1 0",
                     out_valid, out_data, out_count, out_trunc);
        end
        idle();
    endtask

    task automatic test_boundary();
        for (int i = 0; i < 3; i++) put(14'h13C0, 1'b0);
        put(14'h13C0, 1'b1);
        idle();
        nvec++;
        if (out_valid !== 1'b1 || out_data !== 14'h1440 || out_count !== 3'd4 || out_trunc !== 1'b0) begin
            nerr++;
            $display("FAIL last_at_max: vld=%b data=%h cnt=%0d tr=%b want 1 1440 4 0",
                     out_valid, out_data, out_count, out_trunc);
        end
        idle();
    endtask

    task automatic test_nan();
        put(14'h13C0, 1'b0); put(14'h3000, 1'b0); put(14'h13C0, 1'b1);
        idle();
        nvec++;
        if (out_valid !== 1'b1 || out_data[13:12] !== 2'b11 || out_count !== 3'd3) begin
            nerr++;
            $display("FAIL nan: vld=%b data=%h cnt=%0d want 1 exn11 3", out_valid, out_data, out_count);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        put(14'h13C0, 1'b0); put(14'h1400, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        nvec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL rst_mid: vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        put(14'h13C0, 1'b1);
        idle();
        nvec++;
        if (out_valid !== 1'b1 || out_data !== 14'h13C0 || out_count !== 3'd1) begin
            nerr++;
            $display("FAIL rst_mid_next: vld=%b data=%h cnt=%0d want 1 13c0 1",
                     out_valid, out_data, out_count);
        end
        idle();
    endtask

    task automatic test_reset_hold();
        out_ready = 1'b0;
        put(14'h1400, 1'b1);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        nvec++;
        if (out_valid !== 1'b0 || out_data !== 14'h0000 || out_count !== 3'd0 || in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL rst_hold: vld=%b data=%h cnt=%0d rdy=%b want 0 0000 0 1",
                     out_valid, out_data, out_count, in_ready);
        end
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_cancel();
        test_back_to_back();
        test_backpressure();
        test_trunc();
        test_boundary();
        test_nan();
        test_reset_mid();
        test_reset_hold();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
